// File: rtl/wb_regfile_stage.sv
// MIPS write-back stage plus 32x32 architectural register file and retired-instruction counter.
// Optional macro WB_BYPASS_EN enables write-through from the write-back value to the read ports.
module wb_regfile_stage #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 32
) (
    input  logic                        Clock,
    input  logic                        Reset_n,
    input  logic                        RegWriteIn,
    input  logic                        MemToRegIn,
    input  logic [31:0]                 WriteRegisterIn,
    input  logic [31:0]                 ALUResultIn,
    input  logic [31:0]                 DataMemoryIn,
    input  logic [31:0]                 InstructionIn,
    input  logic [$clog2(NUM_REGS)-1:0] ReadReg1,
    input  logic [$clog2(NUM_REGS)-1:0] ReadReg2,
    output logic [31:0]                 ReadData1,
    output logic [31:0]                 ReadData2,
    output logic [31:0]                 WriteDataOut,
    output logic [CNT_W-1:0]            RetiredCount
);

    localparam int AW = $clog2(NUM_REGS);

    logic [31:0]      r_regs [NUM_REGS];
    logic [CNT_W-1:0] r_count;
    logic [AW-1:0]    w_wr_addr;
    logic             w_wr_en;
    logic             w_retire;
    logic             w_unused_wr_bits;

    // Upper destination bits carry no meaning in a 32-entry file.
    assign w_wr_addr        = WriteRegisterIn[AW-1:0];
    assign w_unused_wr_bits = ^WriteRegisterIn[31:AW];

    assign WriteDataOut = MemToRegIn ? DataMemoryIn : ALUResultIn;
    assign w_wr_en      = Reset_n && RegWriteIn && (w_wr_addr != '0);
    assign w_retire     = (InstructionIn != 32'h0);
    assign RetiredCount = r_count;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 32'h0;
            end
            r_count <= '0;
        end else begin
            if (w_wr_en) begin
                r_regs[w_wr_addr] <= WriteDataOut;
            end
            if (w_retire) begin
                r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        ReadData1 = 32'h0;
        ReadData2 = 32'h0;
        if (ReadReg1 != '0) begin
`ifdef WB_BYPASS_EN
            if (w_wr_en && (ReadReg1 == w_wr_addr)) begin
                ReadData1 = WriteDataOut;
            end else begin
                ReadData1 = r_regs[ReadReg1];
            end
`else
            ReadData1 = r_regs[ReadReg1];
`endif
        end
        if (ReadReg2 != '0) begin
`ifdef WB_BYPASS_EN
            if (w_wr_en && (ReadReg2 == w_wr_addr)) begin
                ReadData2 = WriteDataOut;
            end else begin
                ReadData2 = r_regs[ReadReg2];
            end
`else
            ReadData2 = r_regs[ReadReg2];
`endif
        end
    end

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed bench for wb_regfile_stage: driver pushes expected outputs, a negedge monitor pops and compares.
module tb_wb_regfile_stage;

    localparam int K_RD1 = 0;
    localparam int K_RD2 = 1;
    localparam int K_WD  = 2;
    localparam int K_CNT = 3;

    typedef struct {
        int          kind;
        string       name;
        logic [31:0] value;
    } exp_t;

    logic        Clock;
    logic        Reset_n;
    logic        RegWriteIn;
    logic        MemToRegIn;
    logic [31:0] WriteRegisterIn;
    logic [31:0] ALUResultIn;
    logic [31:0] DataMemoryIn;
    logic [31:0] InstructionIn;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] WriteDataOut;
    logic [31:0] RetiredCount;

    exp_t exp_q[$];
    int   total;
    int   bad;

    wb_regfile_stage #(.NUM_REGS(32), .CNT_W(32)) dut (
        .Clock           (Clock),
        .Reset_n         (Reset_n),
        .RegWriteIn      (RegWriteIn),
        .MemToRegIn      (MemToRegIn),
        .WriteRegisterIn (WriteRegisterIn),
        .ALUResultIn     (ALUResultIn),
        .DataMemoryIn    (DataMemoryIn),
        .InstructionIn   (InstructionIn),
        .ReadReg1        (ReadReg1),
        .ReadReg2        (ReadReg2),
        .ReadData1       (ReadData1),
        .ReadData2       (ReadData2),
        .WriteDataOut    (WriteDataOut),
        .RetiredCount    (RetiredCount)
    );

    // clock / reset
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // driver tasks
    task automatic drive(input logic rst_n, input logic rw, input logic m2r,
                         input logic [31:0] wreg, input logic [31:0] alu,
                         input logic [31:0] dmem, input logic [31:0] instr,
                         input logic [4:0] rr1, input logic [4:0] rr2);
        Reset_n         = rst_n;
        RegWriteIn      = rw;
        MemToRegIn      = m2r;
        WriteRegisterIn = wreg;
        ALUResultIn     = alu;
        DataMemoryIn    = dmem;
        InstructionIn   = instr;
        ReadReg1        = rr1;
        ReadReg2        = rr2;
    endtask

    task automatic expect_out(input int kind, input string name, input logic [31:0] value);
        exp_t e;
        e.kind  = kind;
        e.name  = name;
        e.value = value;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge Clock);
        #1;
    endtask

    // scoreboard monitor
    always @(negedge Clock) begin
        while (exp_q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = exp_q.pop_front();
            case (e.kind)
                K_RD1:   act = ReadData1;
                K_RD2:   act = ReadData2;
                K_WD:    act = WriteDataOut;
                default: act = RetiredCount;
            endcase
            total++;
            if (act !== e.value) begin
                bad++;
                $display("FAIL %s: got=0x%08h want=0x%08h at t=%0t", e.name, act, e.value, $time);
            end
        end
    end

    initial begin
        logic [31:0] collide_exp;
        total = 0;
        bad   = 0;
`ifdef WB_BYPASS_EN
        collide_exp = 32'hCAFE_0001;
`else
        collide_exp = 32'h0000_0000;
`endif

        // reset held for two edges with a write and a real instruction presented
        drive(1'b0, 1'b1, 1'b0, 32'd5, 32'h0000_AAAA, 32'h0, 32'h0000_0001, 5'd5, 5'd0);
        next_cycle();
        expect_out(K_RD1, "rst_rd1",  32'h0);
        expect_out(K_RD2, "rst_rd2",  32'h0);
        expect_out(K_CNT, "rst_cnt",  32'h0);
        expect_out(K_WD,  "rst_wd",   32'h0000_AAAA);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd0);
        expect_out(K_RD1, "rst_nocommit", 32'h0);
        expect_out(K_CNT, "rst_cnt2",     32'h0);

        // ALU write to r5
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 32'd5, 32'h1234_5678, 32'h1111_1111, 32'h0085_2820, 5'd3, 5'd0);
        expect_out(K_WD,  "alu_wd",  32'h1234_5678);
        expect_out(K_CNT, "alu_cnt0", 32'h0);

        // load write with masked destination 0x29 -> r9
        next_cycle();
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0029, 32'h0, 32'hDEAD_BEEF, 32'h8C09_0000, 5'd5, 5'd1);
        expect_out(K_RD1, "alu_r5",   32'h1234_5678);
        expect_out(K_RD2, "r1_empty", 32'h0);
        expect_out(K_CNT, "alu_cnt1", 32'd1);
        expect_out(K_WD,  "load_wd",  32'hDEAD_BEEF);

        // write to r0 is dropped but the instruction still retires
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 32'd0, 32'hFFFF_FFFF, 32'h0, 32'h2000_FFFF, 5'd9, 5'd5);
        expect_out(K_RD1, "load_r9",   32'hDEAD_BEEF);
        expect_out(K_RD2, "load_r5",   32'h1234_5678);
        expect_out(K_CNT, "load_cnt",  32'd2);
        expect_out(K_WD,  "r0_wd",     32'hFFFF_FFFF);

        // three bubbles
        next_cycle();
        drive(1'b1, 1'b0, 1'b1, 32'd0, 32'h0000_5555, 32'h7777_7777, 32'h0, 5'd0, 5'd9);
        expect_out(K_RD1, "r0_reads0", 32'h0);
        expect_out(K_RD2, "bub_r9",    32'hDEAD_BEEF);
        expect_out(K_CNT, "r0_cnt",    32'd3);
        expect_out(K_WD,  "bub_wd",    32'h7777_7777);
        next_cycle();
        expect_out(K_CNT, "bub_cnt1", 32'd3);
        expect_out(K_RD2, "bub_r9b",  32'hDEAD_BEEF);
        next_cycle();
        ReadReg1 = 5'd5;
        expect_out(K_CNT, "bub_cnt2", 32'd3);
        expect_out(K_RD1, "bub_r5",   32'h1234_5678);

        // store-like: no RegWrite, still retires
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 32'd5, 32'hBAD0_BAD0, 32'h0, 32'hAC05_0000, 5'd5, 5'd9);
        expect_out(K_CNT, "bub_cnt3", 32'd3);
        expect_out(K_RD1, "st_r5",    32'h1234_5678);

        // collision: write r7 while reading r7
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 32'd7, 32'hCAFE_0001, 32'h0, 32'h2407_0001, 5'd7, 5'd5);
        expect_out(K_RD1, "coll_same", collide_exp);
        expect_out(K_RD2, "st_nowrite", 32'h1234_5678);
        expect_out(K_CNT, "st_cnt",    32'd4);
        expect_out(K_WD,  "coll_wd",   32'hCAFE_0001);

        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'h0, 32'h0, 32'h0, 5'd7, 5'd0);
        expect_out(K_RD1, "coll_next", 32'hCAFE_0001);
        expect_out(K_CNT, "coll_cnt",  32'd5);

        // mid-stream reset: old state visible until the edge, bypass suppressed
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 32'd7, 32'h0000_0099, 32'h0, 32'h0000_0001, 5'd7, 5'd5);
        expect_out(K_RD1, "mrst_old_r7", 32'hCAFE_0001);
        expect_out(K_RD2, "mrst_old_r5", 32'h1234_5678);
        expect_out(K_CNT, "mrst_old_cnt", 32'd5);

        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'h0, 32'h0, 32'h0, 5'd7, 5'd5);
        expect_out(K_RD1, "mrst_r7", 32'h0);
        expect_out(K_RD2, "mrst_r5", 32'h0);
        expect_out(K_CNT, "mrst_cnt", 32'h0);

        @(negedge Clock);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d want=0 pending entries", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_regfile_stage.md
# wb_regfile_stage

Write-back stage and architectural register file for the 32-bit MIPS pipeline. It consumes the MEM/WB pipeline register's outputs, selects the write-back value, and commits it to a 32×32 register file. It also serves the two ID-stage read ports and keeps a retired-instruction counter for the bench and debug. A flushed MEM/WB entry is a bubble: RegWrite=0, MemToReg=1, Instruction=0. This block must treat such an entry as a no-op.

## Interface
Parameters:
- NUM_REGS, 32, register count; address width is log2(NUM_REGS)=5.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- Clock  in  1  single clock; all state changes on the rising edge.
- Reset_n  in  1  reset, synchronous and active-low.
- RegWriteIn  in  1  write enable from MEM/WB.
- MemToRegIn  in  1  1 selects DataMemoryIn, 0 selects ALUResultIn.
- WriteRegisterIn  in  32  destination register; only bits [4:0] are used, bits [31:5] are ignored.
- ALUResultIn  in  32  ALU result.
- DataMemoryIn  in  32  load data.
- InstructionIn  in  32  instruction word; 0 marks a bubble.
- ReadReg1, ReadReg2  in  5  ID-stage read addresses.
- ReadData1, ReadData2  out  32  combinational read data.
- WriteDataOut  out  32  combinational write-back value, for the forwarding unit.
- RetiredCount  out  CNT_W  count of non-bubble instructions retired.

## Operation
- WriteDataOut = MemToRegIn ? DataMemoryIn : ALUResultIn. It is purely combinational.
- Commit occurs on a rising edge when Reset_n=1, RegWriteIn=1 and WriteRegisterIn[4:0]≠0. On commit, Regs[WriteRegisterIn[4:0]] ← WriteDataOut.
- Register 0 always reads 0. A write to register 0 is dropped with no side effects.
- Reads are combinational: ReadDataN = Regs[ReadRegN], or 0 when ReadRegN=0. Bypass behaviour is set under Configuration.
- Counter: on a rising edge with Reset_n=1 and InstructionIn≠0, RetiredCount ← RetiredCount+1. The counter wraps modulo 2^CNT_W with no saturation and no flag.
  - It counts independently of RegWriteIn, so stores and branches count.
  - Bubbles (InstructionIn=0) do not count.
- Reset: while Reset_n=0 at a rising edge, all Regs ← 0 and RetiredCount ← 0. Any commit presented in that same cycle is discarded.
- State is the register array plus the counter. There is no other FSM.

## Timing
- Write latency: data presented in cycle N is visible in Regs after edge N.
- Read latency: 0 cycles (combinational).
- WriteDataOut is valid in the same cycle its inputs are valid.
- RetiredCount reflects instructions presented up to and including cycle N−1.
- Reset is synchronous. Asserting Reset_n=0 mid-stream clears state at the next edge only. Outputs before that edge still show the old state.
- All outputs read 0 after the first reset edge, except WriteDataOut, which follows its inputs.
- Simultaneous write and read of the same address: the result depends on the bypass configuration below.

## Configuration
- WB_BYPASS_EN defined:
  - If RegWriteIn=1, WriteRegisterIn[4:0]≠0 and ReadRegN equals WriteRegisterIn[4:0], then ReadDataN = WriteDataOut in the same cycle (write-through).
  - Bypass is suppressed while Reset_n=0.
- WB_BYPASS_EN undefined:
  - ReadDataN returns the stored (old) value in the colliding cycle. The new value appears the cycle after.
  - The pipeline relies on a write-in-first-half convention elsewhere.

## Test plan
- Reset: hold Reset_n=0 for 2 edges with RegWriteIn=1 and InstructionIn≠0 -> all reads 0, RetiredCount=0, no commit.
- ALU write: RegWriteIn=1, MemToRegIn=0, WriteRegisterIn=5, ALUResultIn=0x1234_5678, InstructionIn=0x0085_2820 -> after edge, ReadReg1=5 gives 0x1234_5678 and RetiredCount=1.
- Load write and bit masking: MemToRegIn=1, WriteRegisterIn=0x0000_0029, DataMemoryIn=0xDEAD_BEEF -> register 9 = 0xDEAD_BEEF and register 5 is unchanged.
- Register 0: write 0xFFFF_FFFF to register 0 -> ReadReg2=0 reads 0. The counter still increments if InstructionIn≠0.
- Bubble: RegWriteIn=0, MemToRegIn=1, InstructionIn=0 for 3 cycles -> register file unchanged and RetiredCount unchanged.
- Collision: write 0xCAFE_0001 to register 7 while ReadReg1=7 -> ReadData1 is 0xCAFE_0001 in the same cycle with WB_BYPASS_EN defined, or the old value without it. Next cycle, both builds read 0xCAFE_0001.
